// File: rtl/memwb_pipe.sv
// MEM/WB pipeline register bank: DEPTH stages of {valid, data, addr, ctrl} with stall, flush and operand forwarding.
// Latency: an entry captured at edge k is visible at the outputs after edge k+DEPTH-1; each stall cycle adds one.
// Backpressure: stall holds every stage; flush overrides stall, shifts, and loads a bubble at stage 0.
// Optional retired-write counter compiled in with `define MEMWB_RETIRE_CNT_EN.
module memwb_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int CTRL_WIDTH = 2,
    parameter int DEPTH      = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] reg_addr_in,
    input  logic [CTRL_WIDTH-1:0] wb_ctrl_in,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ADDR_WIDTH-1:0] reg_addr_out,
    output logic [CTRL_WIDTH-1:0] wb_ctrl_out,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic                  fwd_rs1_hit,
    output logic                  fwd_rs2_hit,
    output logic [DATA_WIDTH-1:0] fwd_rs1_data,
    output logic [DATA_WIDTH-1:0] fwd_rs2_data
`ifdef MEMWB_RETIRE_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  retire_cnt
`endif
);

    // Elaboration-time parameter sanity checks.
    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
        $error("memwb_pipe: DEPTH must be in 1..4");
    end
    if (CNT_WIDTH < 1) begin : g_bad_cnt
        $error("memwb_pipe: CNT_WIDTH must be at least 1");
    end

    typedef struct packed {
        logic                  vld;
        logic [CTRL_WIDTH-1:0] ctrl;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] dat;
    } stage_t;

    stage_t           stage_q [DEPTH];
    stage_t           stage_in;
    logic             shift_en;
    logic [DEPTH-1:0] fwdable;

    // Flush forces a shift even while stalled.
    assign shift_en = flush | ~stall;

    // Stage 0 candidate: a bubble unless a real instruction arrives without flush,
    // so invalid stages never carry stale fields.
    always_comb begin
        stage_in = '0;
        if (!flush && valid_in) begin
            stage_in.vld  = 1'b1;
            stage_in.ctrl = wb_ctrl_in;
            stage_in.addr = reg_addr_in;
            stage_in.dat  = data_in;
        end
    end

    // Stage registers: clear on reset, shift as a unit when enabled, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else if (shift_en) begin
            stage_q[0] <= stage_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign valid_out    = stage_q[DEPTH-1].vld;
    assign data_out     = stage_q[DEPTH-1].dat;
    assign reg_addr_out = stage_q[DEPTH-1].addr;
    assign wb_ctrl_out  = stage_q[DEPTH-1].ctrl;

    // A stage may forward only if it will really write a non-zero register.
    always_comb begin
        fwdable = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwdable[i] = stage_q[i].vld && stage_q[i].ctrl[0] && (stage_q[i].addr != '0);
        end
    end

    // Forwarding match: scan oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_rs1_hit  = 1'b0;
        fwd_rs2_hit  = 1'b0;
        fwd_rs1_data = '0;
        fwd_rs2_data = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (fwdable[i] && stage_q[i].addr == rs1_addr) begin
                fwd_rs1_hit  = 1'b1;
                fwd_rs1_data = stage_q[i].dat;
            end
            if (fwdable[i] && stage_q[i].addr == rs2_addr) begin
                fwd_rs2_hit  = 1'b1;
                fwd_rs2_data = stage_q[i].dat;
            end
        end
    end

`ifdef MEMWB_RETIRE_CNT_EN
    logic retire_fire;

    assign retire_fire = shift_en && stage_q[DEPTH-1].vld && stage_q[DEPTH-1].ctrl[0];

    // Count register writes leaving the final stage; wraps naturally at 2^CNT_WIDTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt <= '0;
        end else if (retire_fire) begin
            retire_cnt <= retire_cnt + 1'b1;
        end
    end
`endif

endmodule
